ad_envelope: RTL and testbench

- Attack/decay envelope generator that sits directly downstream of the rotating bit sequencer.
- Consumes the sequencer's single-bit data_out as a trigger stream and treats each rising edge as a note-on.
- Produces an unsigned amplitude ramp, rising to full scale and then falling to zero, for the downstream VCA/mixer.
- Level changes advance only on the sample tick (ena); trigger edges are captured on every clk.

---
 rtl/ad_envelope.sv | 107 ++++++++++
 tb/tb_ad_envelope.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ad_envelope.sv
// Attack/decay envelope generator.
// A rising edge on trig_in (note-on) starts ATTACK from the current level. The level
// ramps up by atk_step per ena tick to full scale and then ramps down by dec_step to 0.
// Trigger edges are detected on every clk. The level changes only on ena ticks.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   ena      sample tick; the level advances only on clk edges where ena=1
//   trig_in  trigger bit stream; each rising edge is one note-on
//   atk_step amount added per tick in ATTACK (0 = instant attack)
//   dec_step amount subtracted per tick in DECAY (0 = hold at full scale)
//   env_out  current envelope level (registered)
//   busy     high while the generator is not idle
//   eoc      one-clk pulse when the decay reaches 0
module ad_envelope #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              trig_in,
    input  logic [STEP_W-1:0] atk_step,
    input  logic [STEP_W-1:0] dec_step,
    output logic [WIDTH-1:0]  env_out,
    output logic              busy,
    output logic              eoc
);

    // Internal arithmetic width: one bit wider than the wider operand, so the sum cannot wrap.
    localparam int unsigned SW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StAttack,
        StDecay
    } state_e;

    state_e          state;
    logic            trig_prev;
    logic            trig_edge;
    logic [SW-1:0]   env_ext;
    logic [SW-1:0]   atk_ext;
    logic [SW-1:0]   dec_ext;
    logic [SW-1:0]   max_ext;
    logic [SW-1:0]   sum;
    logic [SW-1:0]   diff;

    always_comb begin
        trig_edge = trig_in & ~trig_prev;
        env_ext   = SW'(env_out);
        atk_ext   = SW'(atk_step);
        dec_ext   = SW'(dec_step);
        max_ext   = SW'({WIDTH{1'b1}});
        sum       = env_ext + atk_ext;
        // Used only when env_out > dec_step, so the difference never underflows.
        diff      = env_ext - dec_ext;
        busy      = (state != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            env_out   <= '0;
            eoc       <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_prev <= trig_in;
            eoc       <= 1'b0;
            if (trig_edge) begin
                // A retrigger restarts the attack from the current level. On this clk the
                // level holds, and any decay that would have finished here is abandoned.
                state <= StAttack;
            end else if (ena) begin
                unique case (state)
                    StIdle: begin
                        env_out <= '0;
                    end
                    StAttack: begin
                        if ((atk_step == '0) || (sum >= max_ext)) begin
                            env_out <= {WIDTH{1'b1}};
                            state   <= StDecay;
                        end else begin
                            env_out <= sum[WIDTH-1:0];
                        end
                    end
                    StDecay: begin
                        if (dec_step != '0) begin
                            if (env_ext <= dec_ext) begin
                                env_out <= '0;
                                state   <= StIdle;
                                eoc     <= 1'b1;
                            end else begin
                                env_out <= diff[WIDTH-1:0];
                            end
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad_envelope.sv
// Directed bench for ad_envelope (WIDTH=8). Each step drives the inputs and pushes the
// expected outputs to a scoreboard. After the next rising edge the entry is popped and
// compared with the DUT outputs.
module tb_ad_envelope;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       trig_in;
    logic [7:0] atk_step;
    logic [7:0] dec_step;
    logic [7:0] env_out;
    logic       busy;
    logic       eoc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] env;
        logic       busy;
        logic       eoc;
        string      tag;
    } exp_t;

    exp_t sb[$];

    ad_envelope #(
        .WIDTH (8),
        .STEP_W(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .trig_in (trig_in),
        .atk_step(atk_step),
        .dec_step(dec_step),
        .env_out (env_out),
        .busy    (busy),
        .eoc     (eoc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] e_env, input logic e_busy,
                                 input logic e_eoc);
        chk({tag, ".env"}, 32'(env_out), 32'(e_env));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".eoc"}, 32'(eoc), 32'(e_eoc));
    endtask

    // Drive one clk of stimulus, push the expectation, then pop and compare after the edge.
    task automatic tick(input logic en, input logic tr, input logic [7:0] e_env,
                        input logic e_busy, input logic e_eoc, input string tag);
        exp_t e;
        ena     = en;
        trig_in = tr;
        sb.push_back('{env: e_env, busy: e_busy, eoc: e_eoc, tag: tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(e.tag, e.env, e.busy, e.eoc);
    endtask

    // Full decay from 255 with dec_step=32: 223 ... 31, then 0 with eoc.
    task automatic decay_from_full(input string tag);
        for (int v = 223; v >= 31; v -= 32) tick(1'b1, 1'b0, 8'(v), 1'b1, 1'b0, tag);
        tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, {tag, ".end"});
        tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, {tag, ".idle"});
    endtask

    logic [7:0] levels [12];
    int         n;
    logic       en_i;
    logic [7:0] e_env;

    initial begin
        levels = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd223, 8'd191, 8'd159, 8'd127, 8'd95,
                   8'd63, 8'd31, 8'd0};
        rst      = 1'b0;
        ena      = 1'b0;
        trig_in  = 1'b0;
        atk_step = 8'd64;
        dec_step = 8'd32;
        #2;
        check_outputs("reset", 8'd0, 1'b0, 1'b0);
        #10;
        rst = 1'b1;
        tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, "idle");

        // Single pulse, ena every clk.
        tick(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, "t1.edge");
        tick(1'b1, 1'b0, 8'd64, 1'b1, 1'b0, "t1.a1");
        tick(1'b1, 1'b0, 8'd128, 1'b1, 1'b0, "t1.a2");
        tick(1'b1, 1'b0, 8'd192, 1'b1, 1'b0, "t1.a3");
        tick(1'b1, 1'b0, 8'd255, 1'b1, 1'b0, "t1.sat");
        decay_from_full("t1.dec");

        // ena every 4th clk, trig held high for 20 clks: one edge, each level held 4 clks.
        n = 0;
        for (int i = 0; i < 52; i++) begin
            en_i = ((i % 4) == 3);
            if (en_i) n++;
            e_env = (n == 0 || n > 12) ? 8'd0 : levels[n-1];
            tick(en_i, (i < 20), e_env, (n < 12), (en_i && n == 12), "t2.slow");
        end

        // Retrigger mid-decay at 159.
        tick(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, "t3.edge");
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, levels[k], 1'b1, 1'b0, "t3.ramp");
        tick(1'b1, 1'b1, 8'd159, 1'b1, 1'b0, "t3.retrig");
        tick(1'b1, 1'b0, 8'd223, 1'b1, 1'b0, "t3.a1");
        tick(1'b1, 1'b0, 8'd255, 1'b1, 1'b0, "t3.a2");
        decay_from_full("t3.dec");

        // Instant attack, hold at full scale.
        atk_step = 8'd0;
        dec_step = 8'd0;
        tick(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, "t4.edge");
        tick(1'b1, 1'b0, 8'd255, 1'b1, 1'b0, "t4.inst");
        for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 8'd255, 1'b1, 1'b0, "t4.hold");
        atk_step = 8'd64;
        dec_step = 8'd32;
        tick(1'b1, 1'b1, 8'd255, 1'b1, 1'b0, "t4.retrig");
        tick(1'b1, 1'b0, 8'd255, 1'b1, 1'b0, "t4.sat");
        decay_from_full("t4.dec");

        // Asynchronous reset mid-attack at 128.
        tick(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, "t5.edge");
        tick(1'b1, 1'b0, 8'd64, 1'b1, 1'b0, "t5.a1");
        tick(1'b1, 1'b0, 8'd128, 1'b1, 1'b0, "t5.a2");
        #3;
        rst = 1'b0;
        #1;
        check_outputs("t5.async_rst", 8'd0, 1'b0, 1'b0);

        // Release reset with trig already high.
        trig_in = 1'b1;
        #2;
        rst = 1'b1;
        tick(1'b1, 1'b1, 8'd0, 1'b1, 1'b0, "t6.first");
        tick(1'b1, 1'b0, 8'd64, 1'b1, 1'b0, "t6.a1");
        for (int k = 1; k < 11; k++) tick(1'b1, 1'b0, levels[k], 1'b1, 1'b0, "t6.ramp");

        // Edge coincident with the final decay tick at 31.
        tick(1'b1, 1'b1, 8'd31, 1'b1, 1'b0, "t7.coinc");
        tick(1'b1, 1'b0, 8'd95, 1'b1, 1'b0, "t7.a1");
        tick(1'b1, 1'b0, 8'd159, 1'b1, 1'b0, "t7.a2");
        tick(1'b1, 1'b0, 8'd223, 1'b1, 1'b0, "t7.a3");
        tick(1'b1, 1'b0, 8'd255, 1'b1, 1'b0, "t7.sat");
        decay_from_full("t7.dec");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
